// File: rtl/rs485_pkg.sv
// rs485_pkg: shared types and constants for the RS485 response scheduler
// Contents: FSM state enum, word width, default no-data word, guard tick counter width.
package rs485_pkg;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] NODATA_DEFAULT = 16'hFFFF;
    localparam int TICK_W = 4;
    typedef enum logic [2:0] {ST_IDLE, ST_ARB, ST_LEAD, ST_SEND, ST_TRAIL} state_t;
endpackage

// File: rtl/rs485_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after the last grant
// Ports: req (request vector), last (previous grant index) -> grant (one-hot),
//        idx (granted index, equals last when nothing requests), any_valid.
module rr_arbiter #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [2:0]       last,
    output logic [N_SRC-1:0] grant,
    output logic [2:0]       idx,
    output logic             any_valid
);
    localparam int IW = $clog2(N_SRC);
    logic [IW-1:0] j;
    always_comb begin
        grant = '0;
        idx = last;
        any_valid = 1'b0;
        j = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            j = IW'((int'(last) + i) % N_SRC);
            if (!any_valid && req[j]) begin
                any_valid = 1'b1;
                idx = 3'(j);
                grant[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rs485_tx_scheduler.sv
// rs485_tx_scheduler: per-poll round-robin source pick, driver-enable sequencing and serializer watchdog
// Ports: clk, reset (sync, active-high), baud_tick, poll_detect, src_valid/src_data (sources),
//        src_ack (one-hot take pulse), tx_start/tx_word/tx_done (serializer handshake),
//        de/re_n (transceiver), busy, grant_idx, poll_overrun, tx_fault.
module rs485_tx_scheduler
    import rs485_pkg::*;
#(
    parameter int              N_SRC       = 4,
    parameter int              LEAD_TICKS  = 2,
    parameter int              TRAIL_TICKS = 1,
    parameter int              TX_TIMEOUT  = 1024,
    parameter logic [WORD_W-1:0] NODATA_WORD = NODATA_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    baud_tick,
    input  logic                    poll_detect,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [WORD_W*N_SRC-1:0] src_data,
    output logic [N_SRC-1:0]        src_ack,
    output logic                    tx_start,
    output logic [WORD_W-1:0]       tx_word,
    input  logic                    tx_done,
    output logic                    de,
    output logic                    re_n,
    output logic                    busy,
    output logic [2:0]              grant_idx,
    output logic                    poll_overrun,
    output logic                    tx_fault
);
    localparam int WW = $clog2(TX_TIMEOUT + 1);
    state_t state, nxt;
    logic [TICK_W-1:0] tcnt, tcnt_inc;
    logic [WW-1:0] wd, wd_inc;
    logic [2:0] last, g_idx;
    logic [N_SRC-1:0] grant;
    logic any_valid, lead_done, trail_done, timeout, take;
    logic [WORD_W-1:0] sel_word;

    rr_arbiter #(.N_SRC(N_SRC)) u_arb (
        .req(src_valid), .last(last), .grant(grant), .idx(g_idx), .any_valid(any_valid)
    );

    // Arbitration is resolved at the poll edge so the ack is visible during ARB.
    assign take = (state == ST_IDLE) && poll_detect;
    // The current cycle's tick counts, including in the state-entry cycle.
    assign tcnt_inc = (tcnt == '1) ? tcnt : tcnt + TICK_W'(baud_tick);
    assign wd_inc = (wd == WW'(TX_TIMEOUT)) ? wd : wd + 1'b1;
    assign lead_done = int'(tcnt_inc) >= LEAD_TICKS;
    assign trail_done = int'(tcnt_inc) >= TRAIL_TICKS;
    assign timeout = int'(wd) >= TX_TIMEOUT - 1;
    assign re_n = de;

    always_comb begin
        sel_word = NODATA_WORD;
        for (int i = 0; i < N_SRC; i++)
            if (grant[i]) sel_word = src_data[i*WORD_W +: WORD_W];
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  nxt = poll_detect ? ST_ARB : ST_IDLE;
            ST_ARB:   nxt = ST_LEAD;
            ST_LEAD:  nxt = lead_done ? ST_SEND : ST_LEAD;
            ST_SEND:  nxt = (tx_done || timeout) ? ST_TRAIL : ST_SEND;
            ST_TRAIL: nxt = trail_done ? ST_IDLE : ST_TRAIL;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            tcnt <= '0;
            wd <= '0;
            last <= 3'(N_SRC - 1);
            grant_idx <= 3'(N_SRC - 1);
            tx_word <= NODATA_WORD;
            src_ack <= '0;
            tx_start <= 1'b0;
            de <= 1'b0;
            busy <= 1'b0;
            poll_overrun <= 1'b0;
            tx_fault <= 1'b0;
        end else begin
            state <= nxt;
            tcnt <= (nxt != state) ? '0 : tcnt_inc;
            // With no lead time tx_start fires in LEAD, one cycle before SEND; start the watchdog at 1 then.
            wd <= (nxt != state) ? WW'((nxt == ST_SEND) && (LEAD_TICKS == 0)) : wd_inc;
            src_ack <= take ? grant : '0;
            if (take) begin
                tx_word <= any_valid ? sel_word : NODATA_WORD;
                if (any_valid) begin
                    last <= g_idx;
                    grant_idx <= g_idx;
                end
            end
            tx_start <= (LEAD_TICKS == 0) ? (state == ST_ARB) : (state == ST_LEAD && lead_done);
            de <= (nxt == ST_LEAD) || (nxt == ST_SEND) || (nxt == ST_TRAIL);
            busy <= nxt != ST_IDLE;
            poll_overrun <= poll_detect && (state != ST_IDLE);
            tx_fault <= (state == ST_SEND) && !tx_done && timeout;
        end
    end
endmodule

// File: tb/tb_rs485_tx_scheduler.sv
// tb_rs485_tx_scheduler: table-driven round-robin vectors plus hand sequences for guard, stall, overrun and reset
module tb_rs485_tx_scheduler;
    localparam logic [63:0] DATA = {16'hD333, 16'hC222, 16'hB111, 16'hA000};

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  ack;
        logic [15:0] word;
        logic [2:0]  gidx;
    } vec_t;

    logic clk = 1'b0;
    logic reset, baud_tick, poll_detect, tx_done;
    logic [3:0] src_valid, src_ack;
    logic [63:0] src_data;
    logic tx_start, de, re_n, busy, poll_overrun, tx_fault;
    logic [15:0] tx_word;
    logic [2:0] grant_idx;
    int checks = 0;
    int errors = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    rs485_tx_scheduler #(
        .N_SRC(4), .LEAD_TICKS(2), .TRAIL_TICKS(1), .TX_TIMEOUT(1024), .NODATA_WORD(16'hFFFF)
    ) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .poll_detect(poll_detect),
        .src_valid(src_valid), .src_data(src_data), .src_ack(src_ack), .tx_start(tx_start),
        .tx_word(tx_word), .tx_done(tx_done), .de(de), .re_n(re_n), .busy(busy),
        .grant_idx(grant_idx), .poll_overrun(poll_overrun), .tx_fault(tx_fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic go_send(input vec_t v);
        src_valid = v.valid;
        poll_detect = 1'b1;
        step();
        poll_detect = 1'b0;
        chk("ack", 32'(src_ack), 32'(v.ack));
        chk("word_arb", 32'(tx_word), 32'(v.word));
        chk("gidx", 32'(grant_idx), 32'(v.gidx));
        chk("busy_arb", 32'(busy), 1);
        src_data = ~DATA;
        src_valid = 4'b0000;
        step();
        chk("de_lead", 32'(de), 1);
        chk("re_n_lead", 32'(re_n), 1);
        chk("ack_clear", 32'(src_ack), 0);
        baud_tick = 1'b1;
        step();
        baud_tick = 1'b0;
        chk("start_early", 32'(tx_start), 0);
        repeat (3) step();
        baud_tick = 1'b1;
        step();
        baud_tick = 1'b0;
        chk("start", 32'(tx_start), 1);
    endtask

    task automatic finish_txn(input vec_t v);
        chk("de_trail", 32'(de), 1);
        chk("word_hold", 32'(tx_word), 32'(v.word));
        baud_tick = 1'b1;
        step();
        baud_tick = 1'b0;
        chk("de_off", 32'(de), 0);
        chk("busy_off", 32'(busy), 0);
        src_data = DATA;
    endtask

    task automatic txn(input vec_t v);
        go_send(v);
        step();
        chk("start_pulse", 32'(tx_start), 0);
        repeat (4) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        finish_txn(v);
    endtask

    initial begin
        int n;
        vecs[0] = '{4'b1111, 4'b0001, 16'hA000, 3'd0};
        vecs[1] = '{4'b1111, 4'b0010, 16'hB111, 3'd1};
        vecs[2] = '{4'b1111, 4'b0100, 16'hC222, 3'd2};
        vecs[3] = '{4'b1111, 4'b1000, 16'hD333, 3'd3};
        vecs[4] = '{4'b1111, 4'b0001, 16'hA000, 3'd0};
        vecs[5] = '{4'b0000, 4'b0000, 16'hFFFF, 3'd0};
        vecs[6] = '{4'b0101, 4'b0100, 16'hC222, 3'd2};
        vecs[7] = '{4'b0011, 4'b0001, 16'hA000, 3'd0};
        vecs[8] = '{4'b1000, 4'b1000, 16'hD333, 3'd3};
        vecs[9] = '{4'b1000, 4'b1000, 16'hD333, 3'd3};
        reset = 1'b1;
        baud_tick = 1'b0;
        poll_detect = 1'b0;
        tx_done = 1'b0;
        src_valid = 4'b0000;
        src_data = DATA;
        step();
        step();
        chk("rst_de", 32'(de), 0);
        chk("rst_re_n", 32'(re_n), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_ack", 32'(src_ack), 0);
        chk("rst_overrun", 32'(poll_overrun), 0);
        chk("rst_fault", 32'(tx_fault), 0);
        chk("rst_word", 32'(tx_word), 32'hFFFF);
        chk("rst_gidx", 32'(grant_idx), 3);
        reset = 1'b0;
        step();
        for (int i = 0; i < 10; i++) txn(vecs[i]);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("done_idle_busy", 32'(busy), 0);
        chk("done_idle_de", 32'(de), 0);
        go_send('{4'b1111, 4'b0001, 16'hA000, 3'd0});
        n = 0;
        for (int i = 1; i <= 1100; i++) begin
            step();
            if (tx_fault) begin
                n = i;
                break;
            end
        end
        chk("fault_delay", n, 1024);
        chk("fault_de", 32'(de), 1);
        step();
        chk("fault_pulse", 32'(tx_fault), 0);
        finish_txn('{4'b1111, 4'b0001, 16'hA000, 3'd0});
        go_send('{4'b1111, 4'b0010, 16'hB111, 3'd1});
        repeat (1022) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("done_wins", 32'(tx_fault), 0);
        finish_txn('{4'b1111, 4'b0010, 16'hB111, 3'd1});
        go_send('{4'b1111, 4'b0100, 16'hC222, 3'd2});
        src_valid = 4'b1111;
        poll_detect = 1'b1;
        step();
        poll_detect = 1'b0;
        chk("overrun", 32'(poll_overrun), 1);
        chk("overrun_ack", 32'(src_ack), 0);
        chk("overrun_busy", 32'(busy), 1);
        step();
        chk("overrun_pulse", 32'(poll_overrun), 0);
        chk("overrun_gidx", 32'(grant_idx), 2);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        finish_txn('{4'b1111, 4'b0100, 16'hC222, 3'd2});
        src_valid = 4'b1111;
        poll_detect = 1'b1;
        step();
        poll_detect = 1'b0;
        chk("pre_rst_ack", 32'(src_ack), 32'b1000);
        step();
        chk("pre_rst_de", 32'(de), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_lead_de", 32'(de), 0);
        chk("rst_lead_busy", 32'(busy), 0);
        chk("rst_lead_start", 32'(tx_start), 0);
        chk("rst_lead_gidx", 32'(grant_idx), 3);
        chk("rst_lead_word", 32'(tx_word), 32'hFFFF);
        for (int i = 0; i < 3; i++) begin
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
            chk("rst_idle_start", 32'(tx_start), 0);
            chk("rst_idle_de", 32'(de), 0);
        end
        txn('{4'b1111, 4'b0001, 16'hA000, 3'd0});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
